// File: rtl/eth_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkg
// Shared Ethernet definitions for the RMII receive (and later transmit) path:
//   - rx_state_e   : receive framer state encoding
//   - CRC_POLY     : IEEE 802.3 CRC-32 polynomial, normal (MSB-first) form
//   - CRC_INIT     : CRC register start value
//   - CRC_RESIDUE  : magic remainder, normal form, left after data + FCS
//   - DIBIT_*      : RMII dibit values seen during preamble/SFD
//   - bit_reverse32: maps between normal and reflected CRC bit orders
// ---------------------------------------------------------------------------
package eth_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA,
      ST_DROP
   } rx_state_e;

   localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

   // 0x55 arrives as 01 dibits, 0xD5 ends with a single 11 dibit.
   localparam logic [1:0] DIBIT_IDLE = 2'b00;
   localparam logic [1:0] DIBIT_PRE  = 2'b01;
   localparam logic [1:0] DIBIT_BAD  = 2'b10;
   localparam logic [1:0] DIBIT_SFD  = 2'b11;

   function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/crc32_d2.sv
// ---------------------------------------------------------------------------
// crc32_d2
// Combinational next-state of the reflected Ethernet CRC-32 register for one
// RMII dibit. The register is kept in reflected order (bit 0 is the oldest
// bit), so the dibit is consumed LSB first exactly as it arrives on the wire.
// Ports:
//   crc_in  [31:0] in   current CRC register (reflected order)
//   din     [1:0]  in   received dibit, din[0] is the earlier bit
//   crc_out [31:0] out  CRC register after both bits
// ---------------------------------------------------------------------------
module crc32_d2
   import eth_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [1:0]  din,
   output logic [31:0] crc_out
);

   localparam logic [31:0] POLY_REFL = bit_reverse32(CRC_POLY);

   always_comb begin
      logic [31:0] crc_v;
      crc_v = crc_in;
      for (int i = 0; i < 2; i++) begin
         if (crc_v[0] ^ din[i]) begin
            crc_v = (crc_v >> 1) ^ POLY_REFL;
         end else begin
            crc_v = crc_v >> 1;
         end
      end
      crc_out = crc_v;
   end

endmodule

// File: rtl/rmii_rx_framer.sv
// ---------------------------------------------------------------------------
// rmii_rx_framer
// RMII (100 Mb/s) receive framer: strips preamble/SFD, assembles bytes from
// LSB-first dibits, checks the FCS and length, and streams frame bytes
// (destination MAC through FCS) with a one-byte lag so the final byte can be
// tagged with rx_last / rx_err / rx_len.
// Parameters:
//   MIN_LEN  minimum good frame length in bytes (destination through FCS)
//   MAX_LEN  maximum good frame length in bytes (destination through FCS)
// Ports:
//   clk_mac         in   50 MHz RMII reference clock, one dibit per cycle
//   rst             in   synchronous active-high reset
//   eth_crsdv       in   PHY carrier-sense / data-valid
//   eth_rxd   [1:0] in   PHY receive dibit, LSB first
//   eth_rxerr       in   PHY receive error
//   rx_data   [7:0] out  frame byte
//   rx_valid        out  one-cycle strobe qualifying rx_data
//   rx_last         out  with rx_valid on the final (FCS) byte
//   rx_err          out  with rx_last: 1 = bad frame
//   rx_len   [10:0] out  frame byte count, valid with rx_last (saturates)
// ---------------------------------------------------------------------------
module rmii_rx_framer
   import eth_pkg::*;
#(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1522
) (
   input  logic        clk_mac,
   input  logic        rst,
   input  logic        eth_crsdv,
   input  logic [1:0]  eth_rxd,
   input  logic        eth_rxerr,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        rx_last,
   output logic        rx_err,
   output logic [10:0] rx_len
);

   localparam logic [10:0] LEN_SAT   = 11'h7FF;
   localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
   localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);

   // Input registers: every decision below uses these copies only.
   logic        crsdv_q, crsdv_d;
   logic [1:0]  rxd_q, rxd_d;
   logic        rxerr_q, rxerr_d;

   rx_state_e   state_q, state_d;
   logic [1:0]  pre_cnt_q, pre_cnt_d;     // 01 dibits seen, saturating at 3
   logic [1:0]  idx_q, idx_d;             // dibit position within the byte
   logic [5:0]  sh_q, sh_d;               // first three dibits of the byte
   logic [7:0]  hold_q, hold_d;           // completed byte awaiting output
   logic        hold_vld_q, hold_vld_d;
   logic [31:0] crc_q, crc_d;
   logic [10:0] len_q, len_d;
   logic        err_seen_q, err_seen_d;   // eth_rxerr observed in DATA
   logic        drop_lo_q, drop_lo_d;     // previous DROP cycle had crsdv low

   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        rx_last_q, rx_last_d;
   logic        rx_err_q, rx_err_d;
   logic [10:0] rx_len_q, rx_len_d;

   logic [31:0] crc_next;
   logic [7:0]  byte_done;
   logic        residue_ok;

   crc32_d2 u_crc (
      .crc_in  (crc_q),
      .din     (rxd_q),
      .crc_out (crc_next)
   );

   assign byte_done  = {rxd_q, sh_q};
   // The register is reflected; the residue constant is in normal order.
   assign residue_ok = (bit_reverse32(crc_q) == CRC_RESIDUE);

   always_comb begin
      // NOTE: every _d signal gets its default before the case so no path
      // leaves one unassigned; otherwise synthesis would infer latches.
      crc_d       = crc_q;
      crsdv_d     = eth_crsdv;
      rxd_d       = eth_rxd;
      rxerr_d     = eth_rxerr;
      state_d     = state_q;
      pre_cnt_d   = pre_cnt_q;
      idx_d       = idx_q;
      sh_d        = sh_q;
      hold_d      = hold_q;
      hold_vld_d  = hold_vld_q;
      len_d       = len_q;
      err_seen_d  = err_seen_q;
      drop_lo_d   = drop_lo_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      rx_last_d   = 1'b0;
      rx_err_d    = 1'b0;
      rx_len_d    = rx_len_q;

      case (state_q)
         ST_IDLE: begin
            if (crsdv_q) begin
               state_d   = ST_PREAMBLE;
               pre_cnt_d = 2'd0;
            end
         end

         ST_PREAMBLE: begin
            if (!crsdv_q) begin
               state_d = ST_IDLE;
            end else if (rxerr_q) begin
               state_d   = ST_DROP;
               drop_lo_d = 1'b0;
            end else begin
               case (rxd_q)
                  DIBIT_IDLE: ;
                  DIBIT_PRE: begin
                     if (pre_cnt_q != 2'd3) pre_cnt_d = pre_cnt_q + 2'd1;
                  end
                  DIBIT_SFD: begin
                     if (pre_cnt_q != 2'd0) begin
                        state_d    = ST_DATA;
                        idx_d      = 2'd0;
                        crc_d      = CRC_INIT;
                        len_d      = 11'd0;
                        hold_vld_d = 1'b0;
                        err_seen_d = 1'b0;
                     end else begin
                        state_d   = ST_DROP;
                        drop_lo_d = 1'b0;
                     end
                  end
                  DIBIT_BAD: begin
                     state_d   = ST_DROP;
                     drop_lo_d = 1'b0;
                  end
                  default: ;
               endcase
            end
         end

         ST_DATA: begin
            // Carrier loss only ends the frame on a byte boundary; mid-byte
            // crsdv drops are the PHY toggling and the dibit is still data.
            if (idx_q == 2'd0 && !crsdv_q) begin
               state_d    = ST_IDLE;
               hold_vld_d = 1'b0;
               if (hold_vld_q) begin
                  rx_valid_d = 1'b1;
                  rx_last_d  = 1'b1;
                  rx_data_d  = hold_q;
                  rx_len_d   = len_q;
                  rx_err_d   = !residue_ok || err_seen_q ||
                               (len_q < MIN_LEN_C) || (len_q > MAX_LEN_C);
               end
            end else begin
               crc_d = crc_next;
               sh_d  = {rxd_q, sh_q[5:2]};
               idx_d = idx_q + 2'd1;
               if (rxerr_q) err_seen_d = 1'b1;
               if (idx_q == 2'd3) begin
                  // Release the previous byte; hold this one back so the
                  // frame's final byte is still available at end-of-frame.
                  if (hold_vld_q) begin
                     rx_valid_d = 1'b1;
                     rx_data_d  = hold_q;
                  end
                  hold_d     = byte_done;
                  hold_vld_d = 1'b1;
                  if (len_q != LEN_SAT) len_d = len_q + 11'd1;
               end
            end
         end

         ST_DROP: begin
            if (!crsdv_q) begin
               if (drop_lo_q) state_d = ST_IDLE;
               else           drop_lo_d = 1'b1;
            end else begin
               drop_lo_d = 1'b0;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_mac) begin
      // NOTE: non-blocking assignments so every flop samples its pre-edge
      // value; blocking here would create order-dependent simulation.
      if (rst) begin
         crsdv_q    <= 1'b0;
         rxd_q      <= 2'b00;
         rxerr_q    <= 1'b0;
         state_q    <= ST_IDLE;
         pre_cnt_q  <= 2'd0;
         idx_q      <= 2'd0;
         sh_q       <= 6'd0;
         hold_q     <= 8'h00;
         hold_vld_q <= 1'b0;
         crc_q      <= CRC_INIT;
         len_q      <= 11'd0;
         err_seen_q <= 1'b0;
         drop_lo_q  <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         rx_last_q  <= 1'b0;
         rx_err_q   <= 1'b0;
         rx_len_q   <= 11'd0;
      end else begin
         crsdv_q    <= crsdv_d;
         rxd_q      <= rxd_d;
         rxerr_q    <= rxerr_d;
         state_q    <= state_d;
         pre_cnt_q  <= pre_cnt_d;
         idx_q      <= idx_d;
         sh_q       <= sh_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         crc_q      <= crc_d;
         len_q      <= len_d;
         err_seen_q <= err_seen_d;
         drop_lo_q  <= drop_lo_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_last_q  <= rx_last_d;
         rx_err_q   <= rx_err_d;
         rx_len_q   <= rx_len_d;
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign rx_last  = rx_last_q;
   assign rx_err   = rx_err_q;
   assign rx_len   = rx_len_q;

endmodule
